pe_host_seq: RTL and testbench
==============================

# pe_host_seq

Host-side sequencer for the BRAM-backed matrix-vector processing element. It loads an input stream into the shared BRAM and raises `pe_start` to launch the PE controller. It then waits for the controller's `done`, reads the result words back out of the BRAM, and emits them on an output stream. It sits on the second BRAM port, opposite the PE controller, and it is the initiator side of the controller's start/done handshake.

## Interface
Parameters:
- `BRAM_ADDR_WIDTH`, 15: BRAM byte-address width; upper `BRAM_ADDR` bits are driven 0
- `LOAD_WORDS`, 4160: 32-bit words written per run (64×64 matrix + 64 vector), ≥1
- `RESULT_BASE`, 4160: word index of the first result word
- `RESULT_WORDS`, 64: result words read back per run, ≥1
- `RD_LATENCY`, 1: BRAM read latency in cycles, 1 or 2

Ports:
- `aclk` in 1: single clock; all logic is rising-edge
- `areset` in 1: asynchronous, active-high reset
- `go` in 1: one-cycle run request
- `in_tdata` in 32, `in_tvalid` in 1, `in_tready` out 1: input word stream
- `out_tdata` out 32, `out_tvalid` out 1, `out_tready` in 1, `out_tlast` out 1: result stream
- `pe_start` out 1: one-cycle launch pulse to the PE controller
- `pe_done` in 1: completion level from the PE controller
- `busy` out 1: high whenever state ≠ IDLE
- `run_cycles` out 32: cycles from `pe_start` to `pe_done` in the last run, saturating
- `BRAM_ADDR` out 32, `BRAM_WRDATA` out 32, `BRAM_WE` out 4, `BRAM_CLK` out 1, `BRAM_RDDATA` in 32: BRAM port; `BRAM_CLK` = `aclk`

## Operation
- States: IDLE → LOAD → START → WAIT → RD → RWAIT → OUT, then back to RD or to IDLE.
- **IDLE**: `go`=1 moves to LOAD and clears the word index. `go` in any other state is ignored.
- **LOAD**:
  - `in_tready`=1.
  - Each handshake k registers `BRAM_ADDR`=k·4, `BRAM_WRDATA`=`in_tdata` and `BRAM_WE`=4'hF for the next cycle only. `BRAM_WE`=0 in every other cycle.
  - Accepting word `LOAD_WORDS`−1 moves to START.
- **START**: the final write is on the port in this state; next state is WAIT.
- **WAIT**:
  - `pe_start`=1 only in the first WAIT cycle. The BRAM port is idle (WE=0, ADDR held).
  - The cycle counter increments every WAIT cycle, saturating at 32'hFFFF_FFFF.
  - `pe_done`=1 sampled moves to RD, loads `run_cycles` from the counter, and clears the result index.
- **RD**: drives `BRAM_ADDR`=(`RESULT_BASE`+i)·4; next state is RWAIT.
- **RWAIT**: waits `RD_LATENCY` cycles, then captures `BRAM_RDDATA` into `out_tdata` and moves to OUT.
- **OUT**:
  - `out_tvalid`=1 and `out_tlast`=(i==`RESULT_WORDS`−1). Data is held stable until `out_tready`.
  - On handshake: if last, go to IDLE; otherwise increment i and go to RD.
- `pe_done` is ignored outside WAIT. A `pe_done` already high on WAIT entry completes the run after one counted cycle (`run_cycles`=1).
- Index widths are $clog2 of the word counts. Address arithmetic truncates to `BRAM_ADDR_WIDTH`.

## Timing
- Reset (async assert): state IDLE. Every output is 0: `in_tready`, `out_tvalid`, `out_tlast`, `out_tdata`, `pe_start`, `busy`, `run_cycles`, `BRAM_ADDR`, `BRAM_WRDATA`, `BRAM_WE`. Indices and counter are cleared.
- Reset mid-run: the run is abandoned. Any pending write is dropped, and a `pe_start` pulse in flight is dropped.
- `go` sampled at edge E gives `in_tready`=1 in the cycle after E.
- The write for a word accepted at edge E appears on the port in the cycle after E.
- When the last word is accepted at edge E, `pe_start` is high in the cycle after E+1 (exactly one cycle).
- Per result word, from RD entry to `out_tvalid`: 1+`RD_LATENCY` cycles, plus any backpressure.
- All outputs are registered.

## Structure
- The shared package holds the state enum, `BRAM_WE_FULL`=4'hF, and the byte-per-word shift of 2.
- One sub-module, `sat_counter32`: enable, clear, and load-to-output, saturating.

## Test plan
All scenarios use `LOAD_WORDS`=4, `RESULT_BASE`=4, `RESULT_WORDS`=2, `RD_LATENCY`=1, with a BRAM model and a PE stub. The stub raises `pe_done` 10 cycles after `pe_start` and writes 0xA0, 0xA1 to words 4 and 5.

- Load and launch: `go`, then stream 0x11..0x14 → writes to bytes 0, 4, 8, 12 with WE=F. `pe_start` is a single pulse in the cycle after the last write.
- Readback: after `pe_done` → `out_tdata` 0xA0, then 0xA1 with `out_tlast` on 0xA1. `run_cycles`=10. `busy` drops after the last handshake.
- Backpressure: `in_tvalid` gapped on the input and `out_tready` low for 5 cycles on 0xA0 → data held stable, no duplicate or lost words.
- Ignored inputs: `go` pulsed during WAIT and `pe_done` forced high during LOAD → no state change, no extra `pe_start`.
- Reset mid-LOAD after 2 words → all outputs 0 within the same cycle. A new `go` restarts at byte address 0.
- `RD_LATENCY`=2 variant → first `out_tvalid` 3 cycles after RD entry, data correct.

Source files
------------

// File: rtl/pe_host_seq_pkg.sv
// Shared types and constants for the PE host sequencer: FSM states,
// BRAM write-enable pattern and the word-to-byte address shift.
package pe_host_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_WAIT,
    ST_RD,
    ST_RWAIT,
    ST_OUT
  } state_e;

  localparam logic [3:0]  BRAM_WE_FULL = 4'hF;
  localparam int unsigned WORD_SHIFT   = 2;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/pe_host_seq_if.sv
// Bundle of the sequencer's run control, input/output streams, PE handshake
// and BRAM port. master = sequencer side, slave = environment side.
interface pe_host_seq_if;

  logic        go;
  logic [31:0] in_tdata;
  logic        in_tvalid;
  logic        in_tready;
  logic [31:0] out_tdata;
  logic        out_tvalid;
  logic        out_tready;
  logic        out_tlast;
  logic        pe_start;
  logic        pe_done;
  logic        busy;
  logic [31:0] run_cycles;
  logic [31:0] BRAM_ADDR;
  logic [31:0] BRAM_WRDATA;
  logic [3:0]  BRAM_WE;
  logic        BRAM_CLK;
  logic [31:0] BRAM_RDDATA;

  modport master (
    input  go, in_tdata, in_tvalid, out_tready, pe_done, BRAM_RDDATA,
    output in_tready, out_tdata, out_tvalid, out_tlast, pe_start, busy,
           run_cycles, BRAM_ADDR, BRAM_WRDATA, BRAM_WE, BRAM_CLK
  );

  modport slave (
    output go, in_tdata, in_tvalid, out_tready, pe_done, BRAM_RDDATA,
    input  in_tready, out_tdata, out_tvalid, out_tlast, pe_start, busy,
           run_cycles, BRAM_ADDR, BRAM_WRDATA, BRAM_WE, BRAM_CLK
  );

endinterface

// File: rtl/pe_host_seq_sat_counter32.sv
// Saturating 32-bit cycle counter; load_i snapshots the value the counter
// holds after this cycle's update into the registered output.
module sat_counter32
  import pe_host_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en_i,
  input  logic        clr_i,
  input  logic        load_i,
  output logic [31:0] value_o
);

  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = sat_inc32(cnt_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      value_o <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (load_i) value_o <= cnt_d;
    end
  end

endmodule

// File: rtl/pe_host_seq.sv
// Host-side sequencer: streams words into the shared BRAM, launches the PE,
// times it, then reads the result words back out onto the output stream.
module pe_host_seq
  import pe_host_seq_pkg::*;
#(
  parameter int unsigned BRAM_ADDR_WIDTH = 15,
  parameter int unsigned LOAD_WORDS      = 4160,
  parameter int unsigned RESULT_BASE     = 4160,
  parameter int unsigned RESULT_WORDS    = 64,
  parameter int unsigned RD_LATENCY      = 1
) (
  input  logic          aclk,
  input  logic          areset,
  pe_host_seq_if.master bus
);

  localparam int unsigned AW     = BRAM_ADDR_WIDTH;
  localparam int unsigned LIDX_W = (LOAD_WORDS > 1) ? $clog2(LOAD_WORDS) : 1;
  localparam int unsigned RIDX_W = (RESULT_WORDS > 1) ? $clog2(RESULT_WORDS) : 1;
  localparam int unsigned LAT_W  = 2;

  state_e              state_q;
  logic [LIDX_W-1:0]   ld_idx_q;
  logic [RIDX_W-1:0]   rd_idx_q;
  logic [LAT_W-1:0]    lat_q;
  logic                in_tready_q;
  logic [31:0]         out_tdata_q;
  logic                out_tvalid_q;
  logic                out_tlast_q;
  logic                pe_start_q;
  logic                busy_q;
  logic [31:0]         addr_q;
  logic [31:0]         wrdata_q;
  logic [3:0]          we_q;
  logic [31:0]         run_cycles;

  // Byte address of a word, truncated to the BRAM address width
  function automatic logic [31:0] word_addr(input logic [31:0] word);
    return 32'(AW'(word << WORD_SHIFT));
  endfunction

  sat_counter32 u_cnt (
    .clk    (aclk),
    .rst    (areset),
    .en_i   (state_q == ST_WAIT),
    .clr_i  (state_q == ST_START),
    .load_i ((state_q == ST_WAIT) && bus.pe_done),
    .value_o(run_cycles)
  );

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q      <= ST_IDLE;
      ld_idx_q     <= '0;
      rd_idx_q     <= '0;
      lat_q        <= '0;
      in_tready_q  <= 1'b0;
      out_tdata_q  <= '0;
      out_tvalid_q <= 1'b0;
      out_tlast_q  <= 1'b0;
      pe_start_q   <= 1'b0;
      busy_q       <= 1'b0;
      addr_q       <= '0;
      wrdata_q     <= '0;
      we_q         <= '0;
    end else begin
      we_q       <= '0;
      pe_start_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.go) begin
            state_q     <= ST_LOAD;
            ld_idx_q    <= '0;
            in_tready_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        ST_LOAD: begin
          // in_tready is held high for the whole state, so tvalid is the handshake
          if (bus.in_tvalid) begin
            addr_q   <= word_addr(32'(ld_idx_q));
            wrdata_q <= bus.in_tdata;
            we_q     <= BRAM_WE_FULL;
            if (ld_idx_q == LIDX_W'(LOAD_WORDS - 1)) begin
              state_q     <= ST_START;
              in_tready_q <= 1'b0;
            end else begin
              ld_idx_q <= ld_idx_q + LIDX_W'(1);
            end
          end
        end
        ST_START: begin
          state_q    <= ST_WAIT;
          pe_start_q <= 1'b1;
        end
        ST_WAIT: begin
          if (bus.pe_done) begin
            state_q  <= ST_RD;
            rd_idx_q <= '0;
            addr_q   <= word_addr(32'(RESULT_BASE));
          end
        end
        ST_RD: begin
          state_q <= ST_RWAIT;
          lat_q   <= '0;
        end
        ST_RWAIT: begin
          if (lat_q == LAT_W'(RD_LATENCY - 1)) begin
            state_q      <= ST_OUT;
            out_tdata_q  <= bus.BRAM_RDDATA;
            out_tvalid_q <= 1'b1;
            out_tlast_q  <= (rd_idx_q == RIDX_W'(RESULT_WORDS - 1));
          end else begin
            lat_q <= lat_q + LAT_W'(1);
          end
        end
        ST_OUT: begin
          if (bus.out_tready) begin
            out_tvalid_q <= 1'b0;
            out_tlast_q  <= 1'b0;
            if (out_tlast_q) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q  <= ST_RD;
              rd_idx_q <= rd_idx_q + RIDX_W'(1);
              addr_q   <= word_addr(32'(RESULT_BASE) + 32'(rd_idx_q) + 32'd1);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_tready   = in_tready_q;
  assign bus.out_tdata   = out_tdata_q;
  assign bus.out_tvalid  = out_tvalid_q;
  assign bus.out_tlast   = out_tlast_q;
  assign bus.pe_start    = pe_start_q;
  assign bus.busy        = busy_q;
  assign bus.run_cycles  = run_cycles;
  assign bus.BRAM_ADDR   = addr_q;
  assign bus.BRAM_WRDATA = wrdata_q;
  assign bus.BRAM_WE     = we_q;
  assign bus.BRAM_CLK    = aclk;

endmodule

// File: tb/tb_pe_host_seq.sv
// Bench for pe_host_seq: two instances (read latency 1 and 2) sharing one
// BRAM model and PE stub, selected by sel; runs are checked against the spec.
module tb_pe_host_seq;

  localparam int unsigned LW = 4;
  localparam int unsigned RB = 4;
  localparam int unsigned RW = 2;

  logic        aclk = 1'b0;
  logic        areset;
  logic        sel;
  logic        go, in_tvalid, out_tready, pe_done;
  logic [31:0] in_tdata;

  always #5 aclk = ~aclk;

  pe_host_seq_if b1 ();
  pe_host_seq_if b2 ();

  pe_host_seq #(.BRAM_ADDR_WIDTH(15), .LOAD_WORDS(LW), .RESULT_BASE(RB),
                .RESULT_WORDS(RW), .RD_LATENCY(1))
    dut1 (.aclk(aclk), .areset(areset), .bus(b1));

  pe_host_seq #(.BRAM_ADDR_WIDTH(15), .LOAD_WORDS(LW), .RESULT_BASE(RB),
                .RESULT_WORDS(RW), .RD_LATENCY(2))
    dut2 (.aclk(aclk), .areset(areset), .bus(b2));

  assign b1.go         = go & ~sel;
  assign b2.go         = go & sel;
  assign b1.in_tdata   = in_tdata;
  assign b2.in_tdata   = in_tdata;
  assign b1.in_tvalid  = in_tvalid & ~sel;
  assign b2.in_tvalid  = in_tvalid & sel;
  assign b1.out_tready = out_tready & ~sel;
  assign b2.out_tready = out_tready & sel;
  assign b1.pe_done    = pe_done;
  assign b2.pe_done    = pe_done;

  logic [31:0] m_addr, m_wrdata, m_out_tdata, m_run_cycles;
  logic [3:0]  m_we;
  logic        m_in_tready, m_out_tvalid, m_out_tlast, m_pe_start, m_busy;

  assign m_addr       = sel ? b2.BRAM_ADDR   : b1.BRAM_ADDR;
  assign m_wrdata     = sel ? b2.BRAM_WRDATA : b1.BRAM_WRDATA;
  assign m_we         = sel ? b2.BRAM_WE     : b1.BRAM_WE;
  assign m_out_tdata  = sel ? b2.out_tdata   : b1.out_tdata;
  assign m_run_cycles = sel ? b2.run_cycles  : b1.run_cycles;
  assign m_in_tready  = sel ? b2.in_tready   : b1.in_tready;
  assign m_out_tvalid = sel ? b2.out_tvalid  : b1.out_tvalid;
  assign m_out_tlast  = sel ? b2.out_tlast   : b1.out_tlast;
  assign m_pe_start   = sel ? b2.pe_start    : b1.pe_start;
  assign m_busy       = sel ? b2.busy        : b1.busy;

  // BRAM model: load area in mem, result words supplied by the PE stub
  logic [31:0] mem [16];
  logic [31:0] res [RW];
  logic [31:0] rdw, rd1, rd2a, rd2b;

  assign rdw = (m_addr[5:2] >= 4'(RB)) ? res[m_addr[2]] : mem[m_addr[5:2]];

  always @(posedge aclk) begin
    if (m_we == 4'hF) mem[m_addr[5:2]] <= m_wrdata;
    rd1  <= rdw;
    rd2a <= rdw;
    rd2b <= rd2a;
  end

  assign b1.BRAM_RDDATA = rd1;
  assign b2.BRAM_RDDATA = rd2b;

  // Event log sampled at the clock edge (pre-update values of the cycle ending)
  int          cyc = 0;
  int          hs_cnt = 0;
  logic [31:0] wq_addr [$];
  logic [31:0] wq_data [$];
  logic [3:0]  wq_we [$];
  int          wq_cyc [$];
  int          sq [$];

  always @(posedge aclk) begin
    cyc <= cyc + 1;
    if (m_we != 4'h0) begin
      wq_addr.push_back(m_addr);
      wq_data.push_back(m_wrdata);
      wq_we.push_back(m_we);
      wq_cyc.push_back(cyc);
    end
    if (m_pe_start) sq.push_back(cyc);
    if (m_out_tvalid && out_tready) hs_cnt <= hs_cnt + 1;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string t);
    chk({t, "/in_tready"},  64'(m_in_tready),  64'(0));
    chk({t, "/out_tvalid"}, 64'(m_out_tvalid), 64'(0));
    chk({t, "/out_tlast"},  64'(m_out_tlast),  64'(0));
    chk({t, "/out_tdata"},  64'(m_out_tdata),  64'(0));
    chk({t, "/pe_start"},   64'(m_pe_start),   64'(0));
    chk({t, "/busy"},       64'(m_busy),       64'(0));
    chk({t, "/run_cycles"}, 64'(m_run_cycles), 64'(0));
    chk({t, "/addr"},       64'(m_addr),       64'(0));
    chk({t, "/wrdata"},     64'(m_wrdata),     64'(0));
    chk({t, "/we"},         64'(m_we),         64'(0));
  endtask

  // One complete run: load, launch, PE stub completes after dly WAIT cycles, read back
  task automatic do_run(input bit fixed, input int dly, input int gap_max, input int bp,
                        input bit done_load, input bit go_wait, input bit done_early);
    logic [31:0] din [LW];
    int wb, sb, hb, rd_c, guard, lat, exp_rc;
    for (int k = 0; k < LW; k++) din[k] = fixed ? 32'h11 + 32'(k) : $urandom;
    for (int i = 0; i < RW; i++) res[i] = fixed ? 32'hA0 + 32'(i) : $urandom;
    wb     = wq_addr.size();
    sb     = sq.size();
    hb     = hs_cnt;
    lat    = sel ? 2 : 1;
    exp_rc = done_early ? 1 : dly;

    @(negedge aclk); go = 1'b1; pe_done = done_load;
    @(negedge aclk); go = 1'b0;
    chk("tready_after_go", 64'(m_in_tready), 64'(1));

    for (int k = 0; k < LW; k++) begin
      in_tvalid = 1'b0;
      repeat ($urandom_range(0, gap_max)) @(negedge aclk);
      in_tvalid = 1'b1;
      in_tdata  = din[k];
      guard = 0;
      while (!m_in_tready && guard < 20) begin @(negedge aclk); guard++; end
      @(negedge aclk);
    end
    in_tvalid = 1'b0;
    in_tdata  = '0;
    pe_done   = done_early;

    guard = 0;
    while (!m_pe_start && guard < 5) begin @(negedge aclk); guard++; end
    chk("pe_start_seen", 64'(m_pe_start), 64'(1));

    if (!done_early) begin
      go = go_wait;
      for (int j = 0; j < dly - 1; j++) begin @(posedge aclk); #1; go = 1'b0; end
      go      = 1'b0;
      pe_done = 1'b1;
    end

    rd_c = -1;
    guard = 0;
    while (!m_out_tvalid && guard < 100) begin
      @(negedge aclk);
      guard++;
      if (rd_c < 0 && m_addr == 32'(RB * 4)) rd_c = cyc;
    end
    chk("tvalid_seen", 64'(m_out_tvalid), 64'(1));
    chk("rd_to_valid", 64'(cyc - rd_c), 64'(1 + lat));
    chk("run_cycles", 64'(m_run_cycles), 64'(exp_rc));

    for (int i = 0; i < RW; i++) begin
      guard = 0;
      while (!m_out_tvalid && guard < 20) begin @(negedge aclk); guard++; end
      chk("out_valid", 64'(m_out_tvalid), 64'(1));
      if (i == 0) begin
        repeat (bp) begin
          @(negedge aclk);
          chk("hold_data", 64'(m_out_tdata), 64'(res[0]));
          chk("hold_valid", 64'(m_out_tvalid), 64'(1));
        end
      end
      chk("out_data", 64'(m_out_tdata), 64'(res[i]));
      chk("out_last", 64'(m_out_tlast), 64'(i == RW - 1));
      out_tready = 1'b1;
      @(negedge aclk);
      out_tready = 1'b0;
    end
    chk("busy_after", 64'(m_busy), 64'(0));
    chk("valid_after", 64'(m_out_tvalid), 64'(0));
    chk("handshakes", 64'(hs_cnt - hb), 64'(RW));

    chk("n_writes", 64'(wq_addr.size() - wb), 64'(LW));
    for (int k = 0; k < LW; k++) begin
      if (wb + k < wq_addr.size()) begin
        chk("wr_addr", 64'(wq_addr[wb + k]), 64'(k * 4));
        chk("wr_data", 64'(wq_data[wb + k]), 64'(din[k]));
        chk("wr_we",   64'(wq_we[wb + k]),   64'(4'hF));
      end
      chk("mem", 64'(mem[k]), 64'(din[k]));
    end
    chk("n_starts", 64'(sq.size() - sb), 64'(1));
    if (sq.size() > sb && wq_cyc.size() >= wb + LW)
      chk("start_after_write", 64'(sq[sb] - wq_cyc[wb + LW - 1]), 64'(1));
    pe_done = 1'b0;
  endtask

  initial begin
    int wb;
    areset = 1'b1; sel = 1'b0; go = 1'b0; in_tvalid = 1'b0;
    out_tready = 1'b0; pe_done = 1'b0; in_tdata = '0;
    repeat (2) @(negedge aclk);
    chk_zero("reset");
    chk("bram_clk", 64'({b2.BRAM_CLK, b1.BRAM_CLK}), 64'({aclk, aclk}));
    areset = 1'b0;
    repeat (2) @(negedge aclk);

    // Directed load/launch/readback with fixed data
    do_run(1'b1, 10, 0, 0, 1'b0, 1'b0, 1'b0);
    // Gapped input, output backpressure, go in WAIT, pe_done during LOAD
    do_run(1'b0, $urandom_range(3, 20), 3, 5, 1'b1, 1'b1, 1'b0);
    // pe_done already high on WAIT entry
    do_run(1'b0, 1, 1, 0, 1'b0, 1'b0, 1'b1);
    for (int r = 0; r < 3; r++)
      do_run(1'b0, $urandom_range(1, 30), 2, $urandom_range(0, 4), 1'b0, 1'b0, 1'b0);

    // Reset in the middle of LOAD after two words
    @(negedge aclk); go = 1'b1;
    @(negedge aclk); go = 1'b0;
    wb = wq_addr.size();
    for (int k = 0; k < 2; k++) begin
      in_tvalid = 1'b1; in_tdata = $urandom;
      @(negedge aclk);
    end
    in_tvalid = 1'b0;
    #1 areset = 1'b1;
    #1 chk_zero("mid_reset");
    @(negedge aclk); areset = 1'b0;
    chk("dropped_write", 64'(wq_addr.size() - wb), 64'(1));
    do_run(1'b0, $urandom_range(2, 12), 1, 2, 1'b0, 1'b0, 1'b0);

    // Read latency 2 instance
    @(negedge aclk); sel = 1'b1;
    @(negedge aclk);
    do_run(1'b1, 10, 0, 0, 1'b0, 1'b0, 1'b0);
    do_run(1'b0, $urandom_range(3, 20), 2, 3, 1'b1, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
